riscv_regdump: RTL

RISCV_REGDUMP -- requirements
Module: riscv_regdump

---
 rtl/riscv_regdump.sv | 127 ++++++++++++
 1 files changed

// File: rtl/riscv_regdump.sv
// Streams a contiguous range of RISC-V integer registers out over a valid/ready port.
// Each beat reads the regfile in FETCH and holds the captured value through SEND.
module riscv_regdump #(
  parameter bit DUMP_X0 = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start_i,
  input  logic [4:0]  first_addr_i,
  input  logic [4:0]  last_addr_i,
  input  logic        abort_i,
  output logic [4:0]  rs_addr_o,
  input  logic [31:0] rs_data_i,
  output logic        dump_valid_o,
  input  logic        dump_ready_i,
  output logic [4:0]  dump_addr_o,
  output logic [31:0] dump_data_o,
  output logic        dump_last_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        range_err_o,
  output logic        aborted_o
);

  typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

  state_t      state_reg, state_next;
  logic [4:0]  cur_addr_reg, cur_addr_next;
  logic [4:0]  last_addr_reg, last_addr_next;
  logic [4:0]  dump_addr_reg, dump_addr_next;
  logic [31:0] dump_data_reg, dump_data_next;
  logic        dump_last_reg, dump_last_next;
  logic        done_reg, done_next;
  logic        range_err_reg, range_err_next;
  logic        aborted_reg, aborted_next;
  logic [4:0]  eff_first;
  logic        handshake;

  assign eff_first = (!DUMP_X0 && first_addr_i == 5'd0) ? 5'd1 : first_addr_i;
  assign handshake = (state_reg == SEND) && dump_ready_i;

  always_comb begin
    state_next     = state_reg;
    cur_addr_next  = cur_addr_reg;
    last_addr_next = last_addr_reg;
    dump_addr_next = dump_addr_reg;
    dump_data_next = dump_data_reg;
    dump_last_next = dump_last_reg;
    done_next      = 1'b0;
    range_err_next = 1'b0;
    aborted_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_i) begin
          if (eff_first <= last_addr_i) begin
            cur_addr_next  = eff_first;
            last_addr_next = last_addr_i;
            state_next     = FETCH;
          end else begin
            done_next      = 1'b1;
            range_err_next = 1'b1;
          end
        end
      end
      FETCH: begin
        if (abort_i) begin
          state_next   = IDLE;
          aborted_next = 1'b1;
        end else begin
          dump_data_next = rs_data_i;
          dump_addr_next = cur_addr_reg;
          dump_last_next = (cur_addr_reg == last_addr_reg);
          state_next     = SEND;
        end
      end
      SEND: begin
        // Completion of the final beat wins over a simultaneous abort.
        if (handshake && dump_last_reg) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else if (abort_i) begin
          state_next   = IDLE;
          aborted_next = 1'b1;
        end else if (handshake) begin
          cur_addr_next = cur_addr_reg + 5'd1;
          state_next    = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      cur_addr_reg  <= 5'd0;
      last_addr_reg <= 5'd0;
      dump_addr_reg <= 5'd0;
      dump_data_reg <= 32'd0;
      dump_last_reg <= 1'b0;
      done_reg      <= 1'b0;
      range_err_reg <= 1'b0;
      aborted_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cur_addr_reg  <= cur_addr_next;
      last_addr_reg <= last_addr_next;
      dump_addr_reg <= dump_addr_next;
      dump_data_reg <= dump_data_next;
      dump_last_reg <= dump_last_next;
      done_reg      <= done_next;
      range_err_reg <= range_err_next;
      aborted_reg   <= aborted_next;
    end
  end

  assign rs_addr_o    = (state_reg == IDLE) ? 5'd0 : cur_addr_reg;
  assign dump_valid_o = (state_reg == SEND);
  assign busy_o       = (state_reg != IDLE);
  assign dump_addr_o  = dump_addr_reg;
  assign dump_data_o  = dump_data_reg;
  assign dump_last_o  = dump_last_reg;
  assign done_o       = done_reg;
  assign range_err_o  = range_err_reg;
  assign aborted_o    = aborted_reg;

endmodule
